// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped write-back data cache:
// cache geometry, address field positions and the controller state encoding.
// Word address layout (30 bits): [1:0] word offset, [4:2] index, [29:5] tag.
// ---------------------------------------------------------------------------
package dcache_pkg;

  // Geometry. TAG_W is derived and must not be set independently.
  localparam int ADDR_W   = 30;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int WORDS    = 1 << OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int BADDR_W  = ADDR_W - OFFSET_W;

  // Address slicing positions.
  localparam int INDEX_LSB = OFFSET_W;
  localparam int TAG_LSB   = OFFSET_W + INDEX_W;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// ---------------------------------------------------------------------------
// dcache_line_array
// Storage for the cache lines: valid, dirty, tag and 128-bit data per line.
// The indexed line is read combinationally. Two write ports share the index:
// a word write (store hit, sets dirty) and a block write (refill, sets valid,
// clears dirty). Block write wins if both are asserted.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (clears valid/dirty)
//   index             line selected for read and write
//   line_valid/dirty  flags of the indexed line
//   line_tag/data     tag and data of the indexed line (word0 in [31:0])
//   word_we/offset/data   single-word store into the indexed line
//   block_we/tag/data     whole-line refill of the indexed line
// ---------------------------------------------------------------------------
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  output logic                line_valid,
  output logic                line_dirty,
  output logic [TAG_W-1:0]    line_tag,
  output logic [BLOCK_W-1:0]  line_data,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_offset,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                block_we,
  input  logic [TAG_W-1:0]    block_tag,
  input  logic [BLOCK_W-1:0]  block_data
);

  logic [LINES-1:0]  valid_vec;
  logic [LINES-1:0]  dirty_vec;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES][WORDS];

  // Per-line flag registers; only these need reset, the tag/data arrays are
  // meaningless while valid is low.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_flags
      logic valid_reg;
      logic dirty_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          dirty_reg <= 1'b0;
        end else if (index == INDEX_W'(gi)) begin
          if (block_we) begin
            valid_reg <= 1'b1;
            dirty_reg <= 1'b0;
          end else if (word_we) begin
            dirty_reg <= 1'b1;
          end
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign dirty_vec[gi] = dirty_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (block_we) begin
      tag_mem[index] <= block_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_mem[index][w] <= block_data[w*WORD_W +: WORD_W];
      end
    end else if (word_we) begin
      data_mem[index][word_offset] <= word_data;
    end
  end

  assign line_valid = valid_vec[index];
  assign line_dirty = dirty_vec[index];
  assign line_tag   = tag_mem[index];

  always_comb begin
    line_data = '0;
    for (int w = 0; w < WORDS; w++) begin
      line_data[w*WORD_W +: WORD_W] = data_mem[index][w];
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// ---------------------------------------------------------------------------
// dcache_wb
// Direct-mapped, write-back, write-allocate data cache between the core's
// memory stage and a slow block memory. Hits complete in the request cycle
// with no stall. A miss on a dirty line writes the old block back first, then
// fetches the new block; after the refill the controller returns to IDLE and
// re-runs the lookup, so a store miss is merged by the ordinary hit path.
// The request is not latched: the core holds it stable while proc_stall=1.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   proc_read/proc_write  load / store request (both set is handled as store)
//   proc_addr             30-bit word address
//   proc_wdata            store data
//   proc_rdata            load data, valid when proc_read=1 and proc_stall=0
//   proc_stall            request not yet served
//   mem_read/mem_write    block fill / write-back request (never both)
//   mem_addr              28-bit block address
//   mem_wdata             write-back block, word0 in [31:0]
//   mem_rdata             fill block, word0 in [31:0]
//   mem_ready             one-cycle completion pulse
// ---------------------------------------------------------------------------
module dcache_wb
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [ADDR_W-1:0]  proc_addr,
  input  logic [WORD_W-1:0]  proc_wdata,
  output logic [WORD_W-1:0]  proc_rdata,
  output logic               proc_stall,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready
);

  state_t state_reg, state_next;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                req;
  logic                hit;
  logic [WORD_W-1:0]   hit_word;

  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                word_we;
  logic                block_we;

  assign req_tag    = proc_addr[ADDR_W-1:TAG_LSB];
  assign req_index  = proc_addr[TAG_LSB-1:INDEX_LSB];
  assign req_offset = proc_addr[OFFSET_W-1:0];
  assign req        = proc_read || proc_write;
  assign hit        = line_valid && (line_tag == req_tag);
  assign hit_word   = line_data[32'(req_offset)*WORD_W +: WORD_W];

  dcache_line_array u_lines (
    .clk         (clk),
    .rst_n       (rst_n),
    .index       (req_index),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .line_tag    (line_tag),
    .line_data   (line_data),
    .word_we     (word_we),
    .word_offset (req_offset),
    .word_data   (proc_wdata),
    .block_we    (block_we),
    .block_tag   (req_tag),
    .block_data  (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // mem_read/mem_write come from the state alone; mem_addr/mem_wdata are
  // built from the held request and the indexed line, so they stay stable
  // for the whole transfer.
  always_comb begin
    state_next = state_reg;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    word_we    = 1'b0;
    block_we   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (proc_write) begin
              word_we = 1'b1;
            end else begin
              proc_rdata = hit_word;
            end
          end else begin
            proc_stall = 1'b1;
            state_next = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {line_tag, req_index};
        mem_wdata  = line_data;
        if (mem_ready) begin
          state_next = ALLOCATE;
        end
      end

      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[ADDR_W-1:OFFSET_W];
        if (mem_ready) begin
          block_we   = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_wb.sv
// ---------------------------------------------------------------------------
// tb_dcache_wb
// Scoreboard bench for dcache_wb. The driver computes each request's expected
// response from a flat reference view of memory plus a direct-mapped
// occupancy model and queues it; a monitor pops and checks whenever the cache
// completes a request. Expected memory transfers are queued separately and
// checked by the memory responder when it completes them.
// ---------------------------------------------------------------------------
module tb_dcache_wb;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dcache_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [29:0] addr;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  typedef struct {
    bit           is_wb;
    logic [27:0]  addr;
    logic [127:0] data;
  } mop_t;

  exp_t exp_q[$];
  mop_t mem_q[$];

  int checks = 0;
  int errors = 0;

  // Latencies the responder uses for the transfer in progress.
  int cur_lw = 1;
  int cur_la = 1;
  bit inject_ready = 1'b0;

  // Reference model: what the core must read, what memory must hold, and
  // which block each direct-mapped slot currently holds.
  logic [31:0]  view    [logic [29:0]];
  logic [127:0] mem_img [logic [27:0]];
  logic [127:0] backing [logic [27:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];

  function automatic logic [127:0] init_block(input logic [27:0] b);
    logic [127:0] r;
    if (b == 28'h4) begin
      r = 128'h44444444_33333333_22222222_11111111;
    end else begin
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = {b[25:0], 6'(w)} ^ 32'hA5A5_0000;
    end
    return r;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    if (mem_img.exists(b)) return mem_img[b];
    return init_block(b);
  endfunction

  function automatic logic [31:0] cpu_word(input logic [29:0] a);
    logic [127:0] blk;
    if (view.exists(a)) return view[a];
    blk = mem_block(a[29:2]);
    return blk[32'(a[1:0])*32 +: 32];
  endfunction

  function automatic logic [127:0] cpu_block(input logic [27:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = cpu_word({b, 2'(w)});
    return r;
  endfunction

  function automatic void model_reset();
    view.delete();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  endtask

  // Issue one request, queue its expectations, hold it until served.
  task automatic issue(input bit wr, input logic [29:0] a, input logic [31:0] d,
                       input int lw, input int la);
    exp_t        e;
    mop_t        m;
    int          idx;
    logic [24:0] tg;
    bit          hit;
    bit          wb;
    int          n;
    idx = int'(a[4:2]);
    tg  = a[29:5];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    if (wb) begin
      m.is_wb = 1'b1;
      m.addr  = {m_tag[idx], a[4:2]};
      m.data  = cpu_block(m.addr);
      mem_img[m.addr] = m.data;
      mem_q.push_back(m);
    end
    if (!hit) begin
      m.is_wb = 1'b0;
      m.addr  = a[29:2];
      m.data  = '0;
      mem_q.push_back(m);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    e.is_read = !wr;
    e.addr    = a;
    e.rdata   = wr ? 32'h0 : cpu_word(a);
    e.stall   = hit ? 0 : (1 + (wb ? lw : 0) + la);
    if (wr) begin
      view[a]      = d;
      m_dirty[idx] = 1'b1;
    end
    exp_q.push_back(e);

    cur_lw     = lw;
    cur_la     = la;
    proc_read  = !wr;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (proc_stall && n < 100);
    if (proc_stall) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: addr %h still stalled after %0d cycles, required completion", a, n);
      finish_test();
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_mem_read", 128'(mem_read), 128'(0));
    chk("idle_mem_write", 128'(mem_write), 128'(0));
    chk("idle_stall", 128'(proc_stall), 128'(0));
    chk("idle_rdata", 128'(proc_rdata), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_test();
    int n;
    cur_la    = 40;
    proc_read = 1'b1;
    proc_addr = 30'h54;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_read && n < 10);
    chk("rst_alloc_entered", 128'(mem_read), 128'(1));
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    proc_read = 1'b0;
    exp_q.delete();
    mem_q.delete();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    inject_ready = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_mem_read_low", 128'(mem_read), 128'(0));
    chk("rst_mem_write_low", 128'(mem_write), 128'(0));
    chk("rst_stall_low", 128'(proc_stall), 128'(0));
    repeat (3) @(negedge clk);
    chk("late_ready_mem_read", 128'(mem_read), 128'(0));
    chk("late_ready_stall", 128'(proc_stall), 128'(0));
    @(posedge clk);
    #1;
    issue(1'b0, 30'h54, 32'h0, 1, 2);
  endtask

  // Monitor: checks every completed request against the queued expectation.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
      end else if (proc_read || proc_write) begin
        if (proc_stall) begin
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: addr %h completed, no request expected", proc_addr);
          stall_cnt = 0;
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 128'(proc_rdata), 128'(e.rdata));
          chk("stall_cycles", 128'(stall_cnt), 128'(e.stall));
          chk("rw_exclusive", 128'(proc_read && proc_write), 128'(0));
          chk("mem_rw_exclusive", 128'(mem_read && mem_write), 128'(0));
          $display("txn %s addr=%h rdata=%h stall=%0d", e.is_read ? "rd" : "wr",
                   e.addr, proc_rdata, stall_cnt);
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic mem_done(input bit is_wb);
    mop_t m;
    if (mem_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL mem_unexpected: got op wb=%0d addr %h, required no memory traffic", is_wb, mem_addr);
      return;
    end
    m = mem_q.pop_front();
    chk("mem_kind", 128'(is_wb), 128'(m.is_wb));
    chk("mem_addr", 128'(mem_addr), 128'(m.addr));
    if (is_wb) begin
      chk("wb_data", mem_wdata, m.data);
      backing[mem_addr] = mem_wdata;
    end
    $display("mem %s addr=%h data=%h", is_wb ? "wb  " : "fill", mem_addr,
             is_wb ? mem_wdata : mem_rdata);
  endtask

  // Memory responder: completes a transfer in its cur_lw/cur_la-th cycle.
  initial begin
    int wcnt;
    int rcnt;
    wcnt      = 0;
    rcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (inject_ready) begin
        inject_ready = 1'b0;
        mem_ready    = 1'b1;
        wcnt         = 0;
        rcnt         = 0;
      end else if (!rst_n) begin
        wcnt = 0;
        rcnt = 0;
      end else begin
        if (mem_write) begin
          wcnt++;
          if (wcnt == cur_lw) begin
            mem_done(1'b1);
            mem_ready = 1'b1;
            wcnt      = 0;
          end
        end else begin
          wcnt = 0;
        end
        if (mem_read) begin
          rcnt++;
          if (rcnt == cur_la) begin
            mem_rdata = backing.exists(mem_addr) ? backing[mem_addr] : init_block(mem_addr);
            mem_done(1'b0);
            mem_ready = 1'b1;
            rcnt      = 0;
          end
        end else begin
          rcnt = 0;
        end
      end
    end
  end

  // Driver.
  initial begin
    bit          wr;
    logic [29:0] a;
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_mem_read", 128'(mem_read), 128'(0));
    chk("reset_mem_write", 128'(mem_write), 128'(0));
    chk("reset_stall", 128'(proc_stall), 128'(0));
    chk("reset_rdata", 128'(proc_rdata), 128'(0));
    @(posedge clk);
    #1;

    // Clean miss with a 5-cycle fill, then hits on the same block.
    issue(1'b0, 30'h10, 32'h0, 1, 5);
    for (int i = 1; i < 4; i++) issue(1'b0, 30'h10 + 30'(i), 32'h0, 1, 1);
    // Store hit then load back.
    issue(1'b1, 30'h11, 32'hDEADBEEF, 1, 1);
    issue(1'b0, 30'h11, 32'h0, 1, 1);
    // Conflict miss on the dirty line: write-back then fill.
    issue(1'b0, 30'h30, 32'h0, 3, 2);
    // Store miss to an invalid line, reload, then evict it.
    issue(1'b1, 30'h42, 32'hCAFEF00D, 1, 3);
    issue(1'b0, 30'h42, 32'h0, 1, 1);
    issue(1'b0, 30'h22, 32'h0, 2, 2);
    idle_cycle();

    reset_test();

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      wr = 1'($urandom_range(0, 1));
      a  = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      a  = {a[29:4] >> 0, a[3:0]};
      a  = {25'(a[29:7]), a[6:2], 2'($urandom_range(0, 3))};
      issue(wr, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
    end

    repeat (3) idle_cycle();
    chk("exp_queue_drained", 128'(exp_q.size()), 128'(0));
    chk("mem_queue_drained", 128'(mem_q.size()), 128'(0));
    finish_test();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- It is the responder on the pipeline core's DCACHE port: it takes word-addressed load/store requests and drives DCACHE_stall back to the core.
- On misses it initiates 128-bit block transfers to a slow main memory.
- It sits between MEM_STAGE and the memory model, in the same clock domain as the core.

Parameters:
- INDEX_W, 3, index bits; number of lines = 2**INDEX_W (8).
- OFFSET_W, 2, word-offset bits within a block (4 words × 32b = 128b); fixed at 2.
- TAG_W, 30-INDEX_W-OFFSET_W (25), tag width, derived; do not override.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- proc_read  in  1  load request (core DCACHE_ren)
- proc_write  in  1  store request (core DCACHE_wen)
- proc_addr  in  30  word address: [1:0] offset, [4:2] index, [29:5] tag
- proc_wdata  in  32  store data
- proc_rdata  out  32  load data, valid when proc_read=1 and proc_stall=0
- proc_stall  out  1  request not yet served; core holds request unchanged
- mem_read  out  1  block fill request
- mem_write  out  1  block write-back request
- mem_addr  out  28  block address
- mem_wdata  out  128  write-back block, word0 in [31:0]
- mem_rdata  in  128  fill block, word0 in [31:0]
- mem_ready  in  1  one-cycle pulse: transfer complete

Behaviour:
- Reset: one clock, synchronous, active-low, as fixed above.
  - Sampled at a clk edge with rst_n=0: every line valid=0 and dirty=0, state=IDLE.
  - Outputs after reset: mem_read=0, mem_write=0, proc_stall=0 while no request, proc_rdata=0 when not reading.
- Reset mid-transfer: the transfer is abandoned. mem_read/mem_write are low in the cycle after the reset edge. Any late mem_ready is ignored in IDLE.
- FSM states: IDLE (compare), WRITEBACK, ALLOCATE. Memory outputs are Moore, decoded from the state only.
- IDLE with no request: proc_stall=0, no state change.
- IDLE, request present, hit (valid && tag match):
  - proc_stall=0 in the same cycle, combinational.
  - Read: proc_rdata = the selected word, combinational.
  - Write: at the clk edge, the word at the offset is replaced by proc_wdata and dirty is set.
- IDLE, miss: proc_stall=1 in the same cycle.
  - Line valid && dirty → WRITEBACK.
  - Otherwise → ALLOCATE.
- WRITEBACK:
  - mem_write=1, mem_addr={old tag, index}, mem_wdata=line data, all held stable.
  - On mem_ready → ALLOCATE.
  - proc_stall=1 throughout.
- ALLOCATE:
  - mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready: line data=mem_rdata, tag written, valid=1, dirty=0, → IDLE.
  - proc_stall=1 throughout.
- After a refill, IDLE re-compares and hits. A store is therefore merged via the normal hit path and leaves the line dirty.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: stall = 1 + La cycles, where La = ALLOCATE cycles including the mem_ready cycle.
  - Dirty miss: stall = 1 + Lw + La.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- mem_read and mem_write are never high together.
- proc_read && proc_write together is illegal. The cache treats it as a write, and the bench asserts it never occurs.
- The core must hold proc_addr/proc_wdata stable while proc_stall=1. The cache does not latch the request.
- No request → no memory traffic and no state change.

Decomposition:
- Shared package dcache_pkg holds:
  - state encoding localparams (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2)
  - field widths: TAG_W, INDEX_W, OFFSET_W, BLOCK_W=128
  - address-slicing helper constants
- One sub-module: dcache_line_array, the storage.
  - Holds valid/dirty/tag/data per line, with synchronous reset of valid/dirty.
  - Combinational read of the indexed line.
  - Write ports: word write (hit store) and block write (refill).

Test Plan:
- Reset, then proc_read addr 0x00000010 → proc_stall=1 same cycle; mem_read=1 with mem_addr=0x0000004; memory returns 0x4444_3333_2222_1111_… after 5 cycles → proc_stall drops, proc_rdata = word0.
- Re-read same block, offsets 1..3 back-to-back → 0 stall cycles each; correct words; no mem_read.
- proc_write 0xDEADBEEF to a hit line, then proc_read same addr → 0xDEADBEEF returned, no memory traffic.
- Conflict miss on the dirty line (same index, different tag) → mem_write with old {tag,index} and a block containing 0xDEADBEEF; after mem_ready, mem_read to the new address; total stall = 1 + Lw + La.
- Write miss to an invalid line → allocate, then merge: the line holds the fetched block with the target word replaced; dirty=1, confirmed by a later eviction write-back.
- rst_n=0 during ALLOCATE, mem_ready arriving after reset → mem_read low the next cycle; ready ignored; subsequent read to the same address misses again.
